// File: rtl/vit_frame_ctrl_if.sv
// vit_frame_ctrl_if: frame handshake and datapath-enable bundle; VIT_FRAME_CTRL_STATS_EN adds frame/stall counters
interface vit_frame_ctrl_if #(parameter int SYM_W = 3);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic [15:0]      brch_data;
  logic             en_brch;
  logic             en_acs;
  logic             en_tb;
  logic [SYM_W-1:0] sym_idx;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
`ifdef VIT_FRAME_CTRL_STATS_EN
  logic [15:0]      frame_cnt;
  logic [15:0]      stall_cnt;
  modport master (output in_valid, in_data, out_ready,
                  input in_ready, brch_data, en_brch, en_acs, en_tb, sym_idx, out_valid, busy, frame_cnt, stall_cnt);
  modport slave  (input in_valid, in_data, out_ready,
                  output in_ready, brch_data, en_brch, en_acs, en_tb, sym_idx, out_valid, busy, frame_cnt, stall_cnt);
`else
  modport master (output in_valid, in_data, out_ready,
                  input in_ready, brch_data, en_brch, en_acs, en_tb, sym_idx, out_valid, busy);
  modport slave  (input in_valid, in_data, out_ready,
                  output in_ready, brch_data, en_brch, en_acs, en_tb, sym_idx, out_valid, busy);
`endif
endinterface

// File: rtl/vit_frame_ctrl.sv
// vit_frame_ctrl: Viterbi frame sequencer (LOAD/BRCH/FLUSH/TB/DONE); VIT_FRAME_CTRL_STATS_EN adds frame_cnt/stall_cnt
module vit_frame_ctrl #(
  parameter int N_SYM   = 8,
  parameter int ACS_LAT = 2,
  parameter int TB_LEN  = 8
) (
  input logic clk,
  input logic rst,
  vit_frame_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BRCH, S_FLUSH, S_TB, S_DONE} state_t;
  localparam int MX1 = N_SYM > ACS_LAT ? N_SYM : ACS_LAT;
  localparam int MX  = MX1 > TB_LEN ? MX1 : TB_LEN;
  localparam int CW  = MX > 1 ? $clog2(MX) : 1;
  localparam int SW  = N_SYM > 1 ? $clog2(N_SYM) : 1;
  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [ACS_LAT-1:0] r_sh;
  logic [15:0]        r_data;
  logic               w_timed;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state != w_next || !w_timed) ? '0 : r_cnt + 1'b1;
      r_sh    <= ACS_LAT'({r_sh, r_state == S_BRCH});
      r_data  <= (r_state == S_IDLE && bus.in_valid) ? bus.in_data : r_data;
    end
  end
  always_comb begin
    w_next  = r_state;
    w_timed = r_state == S_BRCH || r_state == S_FLUSH || r_state == S_TB;
    unique case (r_state)
      S_IDLE:  w_next = bus.in_valid ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = S_BRCH;
      S_BRCH:  w_next = r_cnt == CW'(N_SYM - 1) ? S_FLUSH : S_BRCH;
      S_FLUSH: w_next = r_cnt == CW'(ACS_LAT - 1) ? S_TB : S_FLUSH;
      S_TB:    w_next = r_cnt == CW'(TB_LEN - 1) ? S_DONE : S_TB;
      S_DONE:  w_next = bus.out_ready ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
    bus.in_ready  = r_state == S_IDLE;
    bus.brch_data = r_data;
    bus.en_brch   = r_state == S_BRCH;
    bus.en_acs    = r_sh[ACS_LAT-1];
    bus.en_tb     = r_state == S_TB;
    bus.sym_idx   = r_state == S_BRCH ? r_cnt[SW-1:0] : '0;
    bus.out_valid = r_state == S_DONE;
    bus.busy      = r_state != S_IDLE;
  end
`ifdef VIT_FRAME_CTRL_STATS_EN
  logic [15:0] r_frame, r_stall;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame <= '0;
      r_stall <= '0;
    end else begin
      r_frame <= (r_state == S_DONE && bus.out_ready) ? r_frame + 16'd1 : r_frame;
      r_stall <= (r_state == S_DONE && !bus.out_ready && r_stall != 16'hFFFF) ? r_stall + 16'd1 : r_stall;
    end
  end
  assign bus.frame_cnt = r_frame;
  assign bus.stall_cnt = r_stall;
`endif
endmodule

// File: tb/tb_vit_frame_ctrl.sv
// tb_vit_frame_ctrl: randomized check of two vit_frame_ctrl configurations against a frame-timeline model
module tb_vit_frame_ctrl;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [15:0] in_data;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  vit_frame_ctrl_if #(.SYM_W(3)) b0();
  vit_frame_ctrl_if #(.SYM_W(2)) b1();
  assign b0.in_valid = in_valid;
  assign b0.in_data = in_data;
  assign b0.out_ready = out_ready;
  assign b1.in_valid = in_valid;
  assign b1.in_data = in_data;
  assign b1.out_ready = out_ready;
  vit_frame_ctrl u0 (.clk(clk), .rst(rst), .bus(b0));
  vit_frame_ctrl #(.N_SYM(4), .ACS_LAT(1), .TB_LEN(3)) u1 (.clk(clk), .rst(rst), .bus(b1));
  bit          m_busy [2];
  int          m_t    [2];
  logic [15:0] m_data [2];
  int          m_frm  [2];
  int          m_stl  [2];
  function automatic int ns(int i); return i ? 4 : 8; endfunction
  function automatic int al(int i); return i ? 1 : 2; endfunction
  function automatic int tl(int i); return i ? 3 : 8; endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask
  // Timeline model: t counts cycles from the LOAD cycle (t=0) of the current frame
  task automatic check_inst(input int i);
    logic ir, eb, ea, et, ov, bz;
    logic [15:0] bd;
    int sx, n, a, tb, t, d;
    string p;
    n = ns(i); a = al(i); tb = tl(i); t = m_t[i]; d = 1 + n + a + tb;
    p = i ? "c1." : "c0.";
    if (i == 0) begin
      ir = b0.in_ready; eb = b0.en_brch; ea = b0.en_acs; et = b0.en_tb;
      ov = b0.out_valid; bz = b0.busy; bd = b0.brch_data; sx = int'(b0.sym_idx);
    end else begin
      ir = b1.in_ready; eb = b1.en_brch; ea = b1.en_acs; et = b1.en_tb;
      ov = b1.out_valid; bz = b1.busy; bd = b1.brch_data; sx = int'(b1.sym_idx);
    end
    chk({p, "in_ready"}, 32'(ir), 32'(!m_busy[i]));
    chk({p, "busy"}, 32'(bz), 32'(m_busy[i]));
    chk({p, "en_brch"}, 32'(eb), 32'(m_busy[i] && t >= 1 && t < 1 + n));
    chk({p, "sym_idx"}, 32'(sx), (m_busy[i] && t >= 1 && t < 1 + n) ? 32'(t - 1) : 32'd0);
    chk({p, "en_acs"}, 32'(ea), 32'(m_busy[i] && t >= 1 + a && t < 1 + a + n));
    chk({p, "en_tb"}, 32'(et), 32'(m_busy[i] && t >= 1 + n + a && t < d));
    chk({p, "out_valid"}, 32'(ov), 32'(m_busy[i] && t >= d));
    chk({p, "brch_data"}, 32'(bd), 32'(m_data[i]));
`ifdef VIT_FRAME_CTRL_STATS_EN
    chk({p, "frame_cnt"}, 32'(i ? b1.frame_cnt : b0.frame_cnt), 32'(m_frm[i] & 16'hFFFF));
    chk({p, "stall_cnt"}, 32'(i ? b1.stall_cnt : b0.stall_cnt), 32'(m_stl[i]));
`endif
  endtask
  task automatic step_model(input int i);
    int d;
    d = 1 + ns(i) + al(i) + tl(i);
    if (rst) begin
      m_busy[i] = 0; m_t[i] = 0; m_data[i] = '0; m_frm[i] = 0; m_stl[i] = 0;
    end else if (!m_busy[i]) begin
      if (in_valid) begin m_busy[i] = 1; m_t[i] = 0; m_data[i] = in_data; end
    end else if (m_t[i] >= d) begin
      if (out_ready) begin m_busy[i] = 0; m_frm[i]++; end
      else if (m_stl[i] < 65535) m_stl[i]++;
    end else m_t[i]++;
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      step_model(0); step_model(1);
    end
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      check_inst(0); check_inst(1);
      rst = 1'b0;
      if (c < 25) begin
        in_valid = c == 0; in_data = 16'hB4C1; out_ready = 1'b1;
      end else if (c < 70) begin
        in_valid = 1'b1; in_data = c < 47 ? 16'h0000 : 16'hFFFF; out_ready = 1'b1;
      end else if (c < 110) begin
        in_valid = 1'b1; in_data = 16'($urandom); out_ready = (c % 7) == 0;
      end else if (c == 115) begin
        rst = 1'b1;
      end else begin
        rst = $urandom_range(0, 149) == 0;
        in_valid = ($urandom % 3) != 0;
        in_data = 16'($urandom);
        out_ready = ($urandom % 2) != 0;
      end
      @(posedge clk);
      step_model(0); step_model(1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
